multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath. Sequences each instruction through
//  FETCH/DECODE/EXEC/WB or FETCH/DECODE/BRANCH and drives PC, IR, register-file and ALU controls.
//  Supports the opcode set R-type, addi, sltiu, beq, lui, ori and bne.
//  Sits between instruction memory (req/ack handshake) and the shared ALU/register file.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter instr_cnt_o
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_i        in   1      synchronous reset, active-high
//  run_i        in   1      1 = allow new fetches; 0 = hold in FETCH
//  imem_req_o   out  1      instruction fetch request
//  imem_ack_i   in   1      fetch data valid this cycle
//  instr_op_i   in   6      opcode field from IR output
//  pc_write_o   out  1      PC <= PC+4 this cycle
//  ir_write_o   out  1      IR <= imem data this cycle
//  reg_write_o  out  1      register-file write enable
//  alu_op_o     out  3      ALU operation class
//  alu_src_o    out  1      0 = rt operand, 1 = immediate
//  reg_dst_o    out  1      1 = rd, 0 = rt
//  branch_o     out  1      conditional PC load; datapath qualifies it with the zero flag
//  illegal_o    out  1      1-cycle pulse on an unsupported opcode
//  state_o      out  3      current state, for debug
//  instr_cnt_o  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4. Codes 5-7 go to FETCH on the next cycle.
//  Reset:
//  - state=FETCH, opcode register=0, instr_cnt_o=0.
//  - All outputs are 0 during the reset cycle and the cycle after.
//  - Reset overrides everything else; an ack arriving while rst_i=1 is ignored.
//  - Reset mid-instruction abandons it: no write, no count.
//  FETCH:
//  - imem_req_o = run_i.
//  - When run_i & imem_ack_i: ir_write_o=1 and pc_write_o=1 in the same cycle; next state DECODE.
//  - Otherwise stay in FETCH. If run_i drops before ack, drop req and stay in FETCH.
//  - ack without req is ignored.
//  DECODE:
//  - Capture instr_op_i into the opcode register.
//  - Legal ALU opcode -> EXEC. beq/bne -> BRANCH.
//  - Any other opcode: illegal_o=1 for this cycle, next state FETCH, no write, no count.
//  Opcode decode (alu_op, alu_src, reg_dst):
//    000000 R-type  010,0,1
//    001000 addi    000,1,0
//    001011 sltiu   110,1,0
//    001111 lui     011,1,0
//    001101 ori     100,1,0
//    000100 beq     001,0,0
//    000101 bne     101,0,0
//  EXEC:
//  - alu_op/alu_src/reg_dst driven from the opcode register; reg_write_o=0; next state WB.
//  WB:
//  - Same ALU controls as EXEC, plus reg_write_o=1 for exactly 1 cycle.
//  - instr_cnt_o += 1; next state FETCH.
//  BRANCH:
//  - branch_o=1 for exactly 1 cycle, with that instruction's alu_op and alu_src=0.
//  - instr_cnt_o += 1; next state FETCH.
//  Outputs:
//  - Moore style: a function of state + opcode register only; no combinational path from inputs,
//    except imem_req_o (run_i) and the FETCH strobes (imem_ack_i).
//  - Outside their active states, all control outputs are 0.
//  Latency:
//  - ALU instruction: 4 cycles minimum (ack cycle + DECODE + EXEC + WB).
//  - Branch: 3 cycles minimum.
//  - Every ack-wait cycle adds 1.
//  Counter: instr_cnt_o wraps modulo 2^CNT_W with no flag.
//  Invariant: pc_write_o, reg_write_o and branch_o are never high in the same cycle.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles with imem_ack_i=1 -> all outputs 0, state_o=0, instr_cnt_o=0.
//  2. addi: op=001000, ack immediate -> states 0,1,2,3,0; in WB reg_write_o=1, alu_op_o=000,
//     alu_src_o=1, reg_dst_o=0; count becomes 1.
//  3. bne: op=000101, ack delayed 3 cycles -> imem_req_o held 4 cycles, then DECODE, then BRANCH
//     with branch_o=1, alu_op_o=101, reg_write_o=0; count +1.
//  4. Illegal op=111111 -> illegal_o pulses in DECODE, next state FETCH, count unchanged.
//  5. run_i=0 in FETCH with ack=1 -> no ir_write_o or pc_write_o, state stays 0; raise run_i ->
//     fetch proceeds normally.
//  6. Back-to-back R-type with CNT_W=2, 5 instructions -> count sequence 1,2,3,0,1; rst_i asserted
//     during EXEC of the 6th -> no reg_write_o, state 0, count 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control FSM for the MIPS-subset datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> WB (ALU ops) or FETCH -> DECODE -> BRANCH
// (beq/bne). Supported opcodes: R-type, addi, sltiu, lui, ori, beq, bne.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   run_i        1 = allow new fetches, 0 = hold in FETCH
//   imem_req_o   instruction fetch request (FETCH and run_i)
//   imem_ack_i   fetch data valid this cycle
//   instr_op_i   opcode field from the IR output
//   pc_write_o   PC <= PC+4 this cycle (fetch accept)
//   ir_write_o   IR <= imem data this cycle (fetch accept)
//   reg_write_o  register-file write enable (WB only)
//   alu_op_o     ALU operation class
//   alu_src_o    0 = rt operand, 1 = immediate
//   reg_dst_o    1 = rd, 0 = rt
//   branch_o     conditional PC load, qualified with zero flag by the datapath
//   illegal_o    1-cycle pulse in DECODE on an unsupported opcode
//   state_o      current state, for debug
//   instr_cnt_o  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    input  logic [5:0]       instr_op_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [2:0]       alu_op_o,
    output logic             alu_src_o,
    output logic             reg_dst_o,
    output logic             branch_o,
    output logic             illegal_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_BRANCH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_ILLEGAL = 2'd0,
        K_ALU     = 2'd1,
        K_BRANCH  = 2'd2
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        // NOTE: every field gets a default before the case so that unlisted
        // opcodes produce a defined result rather than inferring storage.
        d = '{kind: K_ILLEGAL, alu_op: 3'b000, alu_src: 1'b0, reg_dst: 1'b0};
        case (op)
            6'b000000: d = '{kind: K_ALU,    alu_op: 3'b010, alu_src: 1'b0, reg_dst: 1'b1};
            6'b001000: d = '{kind: K_ALU,    alu_op: 3'b000, alu_src: 1'b1, reg_dst: 1'b0};
            6'b001011: d = '{kind: K_ALU,    alu_op: 3'b110, alu_src: 1'b1, reg_dst: 1'b0};
            6'b001111: d = '{kind: K_ALU,    alu_op: 3'b011, alu_src: 1'b1, reg_dst: 1'b0};
            6'b001101: d = '{kind: K_ALU,    alu_op: 3'b100, alu_src: 1'b1, reg_dst: 1'b0};
            6'b000100: d = '{kind: K_BRANCH, alu_op: 3'b001, alu_src: 1'b0, reg_dst: 1'b0};
            6'b000101: d = '{kind: K_BRANCH, alu_op: 3'b101, alu_src: 1'b0, reg_dst: 1'b0};
            default:   ;
        endcase
        return d;
    endfunction

    state_t           state_q;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rst_q;       // high for the first cycle after reset
    logic             reg_write_q;
    logic             branch_q;
    logic [2:0]       alu_op_q;
    logic             alu_src_q;
    logic             reg_dst_q;

    dec_t dec_in;   // decode of the live IR opcode, used only in DECODE
    dec_t dec_q;    // decode of the captured opcode, used in EXEC
    logic fetch_go;

    assign dec_in = decode(instr_op_i);
    assign dec_q  = decode(op_q);

    // The cycle right after reset is kept quiet: no request, no accept.
    assign fetch_go = (state_q == S_FETCH) & run_i & imem_ack_i & ~rst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            state_q     <= S_FETCH;
            op_q        <= 6'b000000;
            cnt_q       <= '0;
            rst_q       <= 1'b1;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
            alu_op_q    <= 3'b000;
            alu_src_q   <= 1'b0;
            reg_dst_q   <= 1'b0;
        end else begin
            rst_q       <= 1'b0;
            // Registered Moore controls default to idle and are set only
            // for the state being entered.
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
            alu_op_q    <= 3'b000;
            alu_src_q   <= 1'b0;
            reg_dst_q   <= 1'b0;

            case (state_q)
                S_FETCH: begin
                    if (fetch_go) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= instr_op_i;
                    if (dec_in.kind == K_ALU) begin
                        state_q   <= S_EXEC;
                        alu_op_q  <= dec_in.alu_op;
                        alu_src_q <= dec_in.alu_src;
                        reg_dst_q <= dec_in.reg_dst;
                    end else if (dec_in.kind == K_BRANCH) begin
                        state_q  <= S_BRANCH;
                        branch_q <= 1'b1;
                        alu_op_q <= dec_in.alu_op;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    state_q     <= S_WB;
                    alu_op_q    <= dec_q.alu_op;
                    alu_src_q   <= dec_q.alu_src;
                    reg_dst_q   <= dec_q.reg_dst;
                    reg_write_q <= (dec_q.kind == K_ALU);
                end
                S_WB, S_BRANCH: begin
                    state_q <= S_FETCH;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Reset forces every output low in the reset cycle itself, so an
    // instruction interrupted in WB or BRANCH never writes or branches.
    assign imem_req_o  = (state_q == S_FETCH) & run_i & ~rst_q & ~rst_i;
    assign ir_write_o  = fetch_go & ~rst_i;
    assign pc_write_o  = fetch_go & ~rst_i;
    assign reg_write_o = reg_write_q & ~rst_i;
    assign branch_o    = branch_q & ~rst_i;
    assign alu_op_o    = rst_i ? 3'b000 : alu_op_q;
    assign alu_src_o   = alu_src_q & ~rst_i;
    assign reg_dst_o   = reg_dst_q & ~rst_i;
    // The IR is stable from the fetch edge onward, so the DECODE-cycle
    // illegal flag can look at the live opcode.
    assign illegal_o   = (state_q == S_DECODE) & (dec_in.kind == K_ILLEGAL) & ~rst_i;
    assign state_o     = rst_i ? 3'd0 : state_q;
    assign instr_cnt_o = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CNT_W = 2;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             run_i = 1'b0;
    logic             imem_req_o;
    logic             imem_ack_i = 1'b0;
    logic [5:0]       instr_op_i = 6'b0;
    logic             pc_write_o;
    logic             ir_write_o;
    logic             reg_write_o;
    logic [2:0]       alu_op_o;
    logic             alu_src_o;
    logic             reg_dst_o;
    logic             branch_o;
    logic             illegal_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instr_cnt_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .imem_req_o  (imem_req_o),
        .imem_ack_i  (imem_ack_i),
        .instr_op_i  (instr_op_i),
        .pc_write_o  (pc_write_o),
        .ir_write_o  (ir_write_o),
        .reg_write_o (reg_write_o),
        .alu_op_o    (alu_op_o),
        .alu_src_o   (alu_src_o),
        .reg_dst_o   (reg_dst_o),
        .branch_o    (branch_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o),
        .instr_cnt_o (instr_cnt_o)
    );

    // Snapshot of every output in one cycle.
    typedef struct packed {
        logic       req;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [2:0] aop;
        logic       src;
        logic       dst;
        logic       br;
        logic       ill;
        logic [2:0] st;
        logic [1:0] cnt;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic retire;
    } ent_t;

    // Reference model: a schedule of the cycles each instruction still owes.
    ent_t        sched[$];
    bit          dec_pending = 1'b0;
    bit          post_rst    = 1'b0;
    int unsigned mcnt        = 0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Opcode table: kind 0 = illegal, 1 = ALU, 2 = branch.
    task automatic lookup(input logic [5:0] op, output int kind, output logic [2:0] aop,
                          output logic src, output logic dst);
        kind = 0; aop = 3'b000; src = 1'b0; dst = 1'b0;
        case (op)
            6'b000000: begin kind = 1; aop = 3'b010; src = 1'b0; dst = 1'b1; end
            6'b001000: begin kind = 1; aop = 3'b000; src = 1'b1; end
            6'b001011: begin kind = 1; aop = 3'b110; src = 1'b1; end
            6'b001111: begin kind = 1; aop = 3'b011; src = 1'b1; end
            6'b001101: begin kind = 1; aop = 3'b100; src = 1'b1; end
            6'b000100: begin kind = 2; aop = 3'b001; end
            6'b000101: begin kind = 2; aop = 3'b101; end
            default:   ;
        endcase
    endtask

    function automatic vec_t observe();
        vec_t o;
        o.req = imem_req_o;  o.irw = ir_write_o; o.pcw = pc_write_o;
        o.rw  = reg_write_o; o.aop = alu_op_o;   o.src = alu_src_o;
        o.dst = reg_dst_o;   o.br  = branch_o;   o.ill = illegal_o;
        o.st  = state_o;     o.cnt = instr_cnt_o;
        return o;
    endfunction

    // Drive one cycle of inputs, predict outputs, compare, advance the model.
    task automatic cycle(input logic r, input logic rn, input logic a,
                         input logic [5:0] op, output vec_t o);
        vec_t       e;
        ent_t       ent;
        int         kind;
        logic [2:0] aop;
        logic       src, dst;
        @(negedge clk);
        rst_i = r; run_i = rn; imem_ack_i = a; instr_op_i = op;
        #1;
        e = '0;
        if (r) begin
            sched.delete();
            dec_pending = 1'b0;
            post_rst    = 1'b1;
            mcnt        = 0;
        end else if (post_rst) begin
            post_rst = 1'b0;
        end else if (dec_pending) begin
            dec_pending = 1'b0;
            e.st  = 3'd1;
            e.cnt = mcnt[1:0];
            lookup(op, kind, aop, src, dst);
            if (kind == 1) begin
                ent = '0;
                ent.v.st = 3'd2; ent.v.aop = aop; ent.v.src = src; ent.v.dst = dst;
                sched.push_back(ent);
                ent.v.st = 3'd3; ent.v.rw = 1'b1; ent.retire = 1'b1;
                sched.push_back(ent);
            end else if (kind == 2) begin
                ent = '0;
                ent.v.st = 3'd4; ent.v.aop = aop; ent.v.br = 1'b1; ent.retire = 1'b1;
                sched.push_back(ent);
            end else begin
                e.ill = 1'b1;
            end
        end else if (sched.size() > 0) begin
            ent   = sched.pop_front();
            e     = ent.v;
            e.cnt = mcnt[1:0];
            if (ent.retire) mcnt = (mcnt + 1) % (1 << CNT_W);
        end else begin
            e.req = rn;
            e.irw = rn & a;
            e.pcw = rn & a;
            e.cnt = mcnt[1:0];
            if (rn & a) dec_pending = 1'b1;
        end
        o = observe();
        check("outputs", 32'(o), 32'(e));
        check("write_excl", 32'($countones({o.pcw, o.rw, o.br}) <= 1), 32'd1);
        cyc++;
    endtask

    initial begin
        vec_t o;
        logic [1:0] cnt_seq [5];
        logic [5:0] legal_ops [7];
        logic r, rn, a;
        logic [5:0] op;
        cnt_seq   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        legal_ops = '{6'b000000, 6'b001000, 6'b001011, 6'b001111,
                      6'b001101, 6'b000100, 6'b000101};

        // Reset held 2 cycles with ack high, then a quiet cycle.
        cycle(1, 1, 1, OP_R, o); check("t1_rst_a", 32'(o), 32'd0);
        cycle(1, 1, 1, OP_R, o); check("t1_rst_b", 32'(o), 32'd0);
        cycle(0, 1, 1, OP_R, o); check("t1_after", 32'(o), 32'd0);

        // addi with immediate ack.
        cycle(0, 1, 1, OP_ADDI, o);
        check("t2_fetch_st", o.st, 0); check("t2_fetch_irw", o.irw, 1);
        cycle(0, 1, 0, OP_ADDI, o); check("t2_dec_st", o.st, 1);
        cycle(0, 1, 0, 6'($urandom_range(0, 63)), o);
        check("t2_exec_st", o.st, 2); check("t2_exec_rw", o.rw, 0);
        cycle(0, 1, 0, 6'($urandom_range(0, 63)), o);
        check("t2_wb_st", o.st, 3);   check("t2_wb_rw", o.rw, 1);
        check("t2_wb_aop", o.aop, 0); check("t2_wb_src", o.src, 1);
        check("t2_wb_dst", o.dst, 0);
        cycle(0, 0, 0, OP_R, o);
        check("t2_end_st", o.st, 0);  check("t2_end_cnt", o.cnt, 1);

        // bne with 3 wait cycles before ack.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, OP_R, o);
            check("t3_wait_req", o.req, 1); check("t3_wait_irw", o.irw, 0);
        end
        cycle(0, 1, 1, OP_R, o);
        check("t3_ack_req", o.req, 1); check("t3_ack_pcw", o.pcw, 1);
        cycle(0, 1, 0, OP_BNE, o); check("t3_dec_st", o.st, 1);
        cycle(0, 1, 0, 6'($urandom_range(0, 63)), o);
        check("t3_br_st", o.st, 4);   check("t3_br", o.br, 1);
        check("t3_br_aop", o.aop, 5); check("t3_br_rw", o.rw, 0);
        check("t3_br_src", o.src, 0);
        cycle(0, 0, 0, OP_R, o); check("t3_end_cnt", o.cnt, 2);

        // Illegal opcode.
        cycle(0, 1, 1, OP_R, o);
        cycle(0, 1, 0, 6'h3f, o);
        check("t4_ill", o.ill, 1); check("t4_ill_st", o.st, 1);
        cycle(0, 0, 0, OP_R, o);
        check("t4_next_st", o.st, 0); check("t4_next_ill", o.ill, 0);
        check("t4_cnt", o.cnt, 2);

        // run low blocks fetch even with ack high.
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1, OP_R, o);
            check("t5_hold_irw", o.irw, 0); check("t5_hold_pcw", o.pcw, 0);
            check("t5_hold_st", o.st, 0);   check("t5_hold_req", o.req, 0);
        end
        cycle(0, 1, 1, OP_R, o); check("t5_go_irw", o.irw, 1);
        cycle(0, 1, 0, OP_R, o); check("t5_dec_st", o.st, 1);
        cycle(0, 1, 0, OP_R, o);
        cycle(0, 1, 0, OP_R, o); check("t5_wb_dst", o.dst, 1);

        // Back-to-back R-type, count wraps at CNT_W=2, reset in 6th EXEC.
        cycle(1, 0, 0, OP_R, o);
        cycle(0, 0, 0, OP_R, o);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1, 1, OP_R, o);
            if (k > 0) check($sformatf("t6_cnt_%0d", k), o.cnt, cnt_seq[k-1]);
            cycle(0, 1, 0, OP_R, o);
            if (k < 5) begin
                cycle(0, 1, 0, OP_R, o);
                cycle(0, 1, 0, OP_R, o); check("t6_wb_rw", o.rw, 1);
            end else begin
                cycle(1, 1, 0, OP_R, o); check("t6_rst_exec", 32'(o), 32'd0);
                cycle(0, 1, 0, OP_R, o); check("t6_rst_after", 32'(o), 32'd0);
            end
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            rn = ($urandom_range(0, 3) != 0);
            a  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 6)];
            cycle(r, rn, a, op, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
